// File: rtl/mem_responder_if.sv
// Request/response bus between a memory requester and mem_responder.
// The requester drives the master side; the responder implements the slave side.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              err;

  modport master (
    output req, wr, addr, data_in,
    input  ready, done, data_out, err
  );

  modport slave (
    input  req, wr, addr, data_in,
    output ready, done, data_out, err
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle word memory responder: accepts one load/store at a time and
// completes it LATENCY cycles later, refusing misaligned or out-of-range accesses.
module mem_responder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave mem_if
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic                refused;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign idx     = addr_q[DEPTH_LOG2:1];
  assign refused = addr_q[0] | (|addr_q[ADDR_W-1:DEPTH_LOG2+1]);

  // State and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and completion decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_if.req) begin
          wr_d    = mem_if.wr;
          addr_d  = mem_if.addr;
          wdata_d = mem_if.data_in;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (refused) begin
            err_d = 1'b1;
          end else if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array is deliberately not reset; the write is gated by the reset-cleared state.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign mem_if.ready    = (state_q == IDLE);
  assign mem_if.done     = done_q;
  assign mem_if.err      = err_q;
  assign mem_if.data_out = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=3 instance for the main tests and
// a LATENCY=1 instance for the back-to-back case, sharing one stimulus driver.
module tb_mem_responder;

  logic clk;
  logic rst;
  logic sel;
  logic req_r, wr_r;
  logic [15:0] addr_r, din_r;
  logic ready_w, done_w, err_w;
  logic [15:0] dout_w;

  int n_checks;
  int n_fail;

  logic        vw [4];
  logic [15:0] va [4];
  logic [15:0] vd [4];

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b3 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .mem_if(b3.slave));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_if(b1.slave));

  assign b3.req     = req_r & ~sel;
  assign b3.wr      = wr_r;
  assign b3.addr    = addr_r;
  assign b3.data_in = din_r;
  assign b1.req     = req_r & sel;
  assign b1.wr      = wr_r;
  assign b1.addr    = addr_r;
  assign b1.data_in = din_r;

  assign ready_w = sel ? b1.ready    : b3.ready;
  assign done_w  = sel ? b1.done     : b3.done;
  assign err_w   = sel ? b1.err      : b3.err;
  assign dout_w  = sel ? b1.data_out : b3.data_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated request; checks latency, ready-low span and the one-cycle pulse.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, output logic e, output logic [15:0] q);
    int n;
    int busy;
    @(negedge clk);
    check("ready_idle", 32'(ready_w), 32'd1);
    wr_r = w; addr_r = a; din_r = d; req_r = 1'b1;
    @(posedge clk); #1;
    req_r = 1'b0;
    n = 0;
    busy = 0;
    while (!done_w && n < 20) begin
      if (!ready_w) busy++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_cycles", 32'(busy), 32'(lat));
    e = err_w;
    q = dout_w;
    @(posedge clk); #1;
    check("done_pulse", 32'(done_w), 32'd0);
    check("err_pulse", 32'(err_w), 32'd0);
  endtask

  // req held high over vw/va/vd; accepts are expected every lat+1 cycles.
  task automatic stream(input int nreq, input int lat, input int ncyc);
    int idx;
    int nd;
    int run;
    int max_run;
    int acc_cyc [4];
    logic acc;
    idx = 0; nd = 0; run = 0; max_run = 0;
    for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
    @(negedge clk);
    wr_r = vw[0]; addr_r = va[0]; din_r = vd[0]; req_r = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      acc = ready_w && req_r;
      @(posedge clk); #1;
      if (acc && idx < 4) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < nreq) begin
          wr_r = vw[idx]; addr_r = va[idx]; din_r = vd[idx];
        end else begin
          req_r = 1'b0;
        end
      end
      if (!ready_w) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done_w) begin
        if (nd < nreq && !vw[nd]) check("stream_load", 32'(dout_w), 32'(vd[nd]));
        check("stream_err", 32'(err_w), 32'd0);
        nd++;
      end
    end
    req_r = 1'b0;
    check("stream_accepts", 32'(idx), 32'(nreq));
    for (int i = 0; i < nreq; i++) check("stream_accept_cycle", 32'(acc_cyc[i]), 32'(i * (lat + 1)));
    check("stream_done_count", 32'(nd), 32'(nreq));
    check("ready_low_run", 32'(max_run), 32'(lat));
  endtask

  initial begin
    logic        e;
    logic [15:0] q;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; sel = 1'b0;
    req_r = 1'b0; wr_r = 1'b0; addr_r = '0; din_r = '0;
    #3 rst = 1'b0;
    #20;
    check("rst_ready", 32'(b3.ready), 32'd1);
    check("rst_done", 32'(b3.done), 32'd0);
    check("rst_err", 32'(b3.err), 32'd0);
    check("rst_dout", 32'(b3.data_out), 32'd0);
    check("rst_ready_l1", 32'(b1.ready), 32'd1);
    @(negedge clk) rst = 1'b1;

    access(1'b1, 16'h0010, 16'hBEEF, 3, e, q);
    check("st_beef_err", 32'(e), 32'd0);
    check("st_beef_dout", 32'(q), 32'h0000);
    access(1'b0, 16'h0010, 16'h0000, 3, e, q);
    check("ld_beef", 32'(q), 32'hBEEF);
    check("ld_beef_err", 32'(e), 32'd0);

    access(1'b1, 16'h0010, 16'h1234, 3, e, q);
    access(1'b0, 16'h0010, 16'h0000, 3, e, q);
    check("ld_1234", 32'(q), 32'h1234);
    access(1'b0, 16'h0011, 16'h0000, 3, e, q);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_dout", 32'(q), 32'h1234);
    access(1'b0, 16'h0010, 16'h0000, 3, e, q);
    check("mem8_kept", 32'(q), 32'h1234);

    access(1'b1, 16'h0000, 16'h7777, 3, e, q);
    access(1'b1, 16'h0200, 16'h9999, 3, e, q);
    check("range_err", 32'(e), 32'd1);
    check("range_dout", 32'(q), 32'h1234);
    access(1'b0, 16'h0000, 16'h0000, 3, e, q);
    check("no_alias", 32'(q), 32'h7777);

    vw[0] = 1'b1; va[0] = 16'h0000; vd[0] = 16'h0001;
    vw[1] = 1'b0; va[1] = 16'h0000; vd[1] = 16'h0001;
    vw[2] = 1'b1; va[2] = 16'h0002; vd[2] = 16'h0003;
    vw[3] = 1'b0; va[3] = 16'h0002; vd[3] = 16'h0003;
    stream(4, 3, 18);

    access(1'b1, 16'h0004, 16'h5555, 3, e, q);
    @(negedge clk);
    wr_r = 1'b1; addr_r = 16'h0004; din_r = 16'hAAAA; req_r = 1'b1;
    @(posedge clk); #1;
    req_r = 1'b0;
    check("abort_busy", 32'(ready_w), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready_w), 32'd1);
    check("abort_done", 32'(done_w), 32'd0);
    check("abort_dout", 32'(dout_w), 32'd0);
    repeat (4) @(posedge clk);
    #1 check("abort_no_done", 32'(done_w), 32'd0);
    @(negedge clk) rst = 1'b1;
    access(1'b0, 16'h0004, 16'h0000, 3, e, q);
    check("abort_no_write", 32'(q), 32'h5555);

    sel = 1'b1;
    vw[0] = 1'b1; va[0] = 16'h0006; vd[0] = 16'h00C3;
    vw[1] = 1'b0; va[1] = 16'h0006; vd[1] = 16'h00C3;
    stream(2, 1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
